// File: rtl/lsu_mc_if.sv
// Pipeline-side request/response, DMEM beat port and MMIO bus of the load/store unit.
// Signal names are written from the LSU's point of view; slave = LSU, master = pipeline/memory side.
interface lsu_mc_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_we;
    logic [1:0]        i_size;
    logic              i_unsigned;
    logic [ADDR_W-1:0] i_addr;
    logic [XLEN-1:0]   i_wdata;
    logic              o_rsp_valid;
    logic              o_rsp_err;
    logic [XLEN-1:0]   o_rdata;
    logic              o_dm_req;
    logic              o_dm_we;
    logic [NB-1:0]     o_dm_be;
    logic [ADDR_W-1:0] o_dm_addr;
    logic [XLEN-1:0]   o_dm_wdata;
    logic [XLEN-1:0]   i_dm_rdata;
    logic              o_mmio_we;
    logic              o_mmio_re;
    logic [ADDR_W-1:0] o_mmio_addr;
    logic [XLEN-1:0]   o_mmio_wdata;
    logic [XLEN-1:0]   i_mmio_rdata;

    modport slave (
        input  i_req_valid, i_we, i_size, i_unsigned, i_addr, i_wdata, i_dm_rdata, i_mmio_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_err, o_rdata,
        output o_dm_req, o_dm_we, o_dm_be, o_dm_addr, o_dm_wdata,
        output o_mmio_we, o_mmio_re, o_mmio_addr, o_mmio_wdata
    );

    modport master (
        output i_req_valid, i_we, i_size, i_unsigned, i_addr, i_wdata, i_dm_rdata, i_mmio_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_err, o_rdata,
        input  o_dm_req, o_dm_we, o_dm_be, o_dm_addr, o_dm_wdata,
        input  o_mmio_we, o_mmio_re, o_mmio_addr, o_mmio_wdata
    );
endinterface

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: splits word-crossing DMEM accesses into two beats, rejects misaligned MMIO.
// Latency accept->response: 1 (error), 2 (single beat / MMIO), 3 (split); one request in flight, no queueing.
module lsu_mc #(
    parameter int                XLEN      = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] MMIO_MASK = 32'hF000_0000
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    lsu_mc_if.slave bus
);
    localparam int NB  = XLEN / 8;
    localparam int NB2 = 2 * NB;
    localparam int OW  = $clog2(NB);
    localparam int CW  = OW + 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE_LO, S_ISSUE_HI, S_RESP} state_t;

    state_t            r_state;
    logic              r_we, r_uns, r_split, r_mmio;
    logic [1:0]        r_size;
    logic [OW-1:0]     r_off;
    logic [ADDR_W-1:0] r_addr_al;
    logic [NB-1:0]     r_hi_be;
    logic [XLEN-1:0]   r_hi_wdata, r_lo_word;
    logic              r_dm_req, r_dm_we, r_mmio_we, r_mmio_re, r_rsp_valid, r_rsp_err;
    logic [NB-1:0]     r_dm_be;
    logic [ADDR_W-1:0] r_dm_addr, r_mmio_addr;
    logic [XLEN-1:0]   r_dm_wdata, r_mmio_wdata;

    logic [OW-1:0]     w_off;
    logic [CW-1:0]     w_nbytes, w_rnb;
    logic              w_mmio, w_split, w_err, w_sign;
    logic [NB2-1:0]    w_be2;
    logic [2*XLEN-1:0] w_wd2, w_pair;
    logic [ADDR_W-1:0] w_addr_al;
    logic [XLEN-1:0]   w_shift, w_ext;

    // Both beats' enables/data come from one double-width shift: low half is beat 0, high half beat 1.
    always_comb begin
        w_off     = bus.i_addr[OW-1:0];
        w_nbytes  = CW'(1) << bus.i_size;
        w_mmio    = (bus.i_addr & MMIO_MASK) == MMIO_BASE;
        w_split   = !w_mmio && ((CW'(w_off) + w_nbytes) > CW'(NB));
        w_err     = (w_nbytes > CW'(NB)) ||
                    (w_mmio && ((CW'(w_off) & (w_nbytes - CW'(1))) != '0));
        w_be2     = ((NB2'(1) << w_nbytes) - NB2'(1)) << w_off;
        w_wd2     = {{XLEN{1'b0}}, bus.i_wdata} << {w_off, 3'b000};
        w_addr_al = {bus.i_addr[ADDR_W-1:OW], OW'(0)};
    end

    // The last beat's word is never registered: it is taken live from i_dm_rdata in RESP.
    always_comb begin
        if (r_split)
            w_pair = {bus.i_dm_rdata, r_lo_word};
        else if (r_mmio)
            w_pair = {{XLEN{1'b0}}, r_lo_word};
        else
            w_pair = {{XLEN{1'b0}}, bus.i_dm_rdata};
        w_shift = XLEN'(w_pair >> {r_off, 3'b000});
        w_rnb   = CW'(1) << r_size;
        w_sign  = 1'b0;
        for (int b = 0; b < NB; b++)
            if (CW'(b + 1) == w_rnb) w_sign = w_shift[8*b+7];
        w_sign = w_sign & !r_uns;
        w_ext  = w_shift;
        for (int b = 0; b < NB; b++)
            if (CW'(b) >= w_rnb) w_ext[8*b +: 8] = {8{w_sign}};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_split      <= 1'b0;
            r_mmio       <= 1'b0;
            r_size       <= '0;
            r_off        <= '0;
            r_addr_al    <= '0;
            r_hi_be      <= '0;
            r_hi_wdata   <= '0;
            r_lo_word    <= '0;
            r_dm_req     <= 1'b0;
            r_dm_we      <= 1'b0;
            r_dm_be      <= '0;
            r_dm_addr    <= '0;
            r_dm_wdata   <= '0;
            r_mmio_we    <= 1'b0;
            r_mmio_re    <= 1'b0;
            r_mmio_addr  <= '0;
            r_mmio_wdata <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_dm_req     <= 1'b0;
            r_dm_we      <= 1'b0;
            r_dm_be      <= '0;
            r_dm_addr    <= '0;
            r_dm_wdata   <= '0;
            r_mmio_we    <= 1'b0;
            r_mmio_re    <= 1'b0;
            r_mmio_addr  <= '0;
            r_mmio_wdata <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.i_req_valid) begin
                    r_we       <= bus.i_we;
                    r_uns      <= bus.i_unsigned;
                    r_size     <= bus.i_size;
                    r_off      <= w_off;
                    r_addr_al  <= w_addr_al;
                    r_split    <= w_split;
                    r_mmio     <= w_mmio;
                    r_hi_be    <= w_be2[NB2-1:NB];
                    r_hi_wdata <= w_wd2[2*XLEN-1:XLEN];
                    if (w_err) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_state <= S_ISSUE_LO;
                        if (w_mmio) begin
                            r_mmio_we    <= bus.i_we;
                            r_mmio_re    <= !bus.i_we;
                            r_mmio_addr  <= bus.i_addr;
                            r_mmio_wdata <= bus.i_wdata;
                        end else begin
                            r_dm_req   <= 1'b1;
                            r_dm_we    <= bus.i_we;
                            r_dm_be    <= w_be2[NB-1:0];
                            r_dm_addr  <= w_addr_al;
                            r_dm_wdata <= w_wd2[XLEN-1:0];
                        end
                    end
                end
                S_ISSUE_LO: begin
                    if (r_mmio) r_lo_word <= bus.i_mmio_rdata;
                    if (r_split) begin
                        r_state    <= S_ISSUE_HI;
                        r_dm_req   <= 1'b1;
                        r_dm_we    <= r_we;
                        r_dm_be    <= r_hi_be;
                        r_dm_addr  <= r_addr_al + ADDR_W'(NB);
                        r_dm_wdata <= r_hi_wdata;
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_ISSUE_HI: begin
                    r_lo_word   <= bus.i_dm_rdata;
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_req_ready  = (r_state == S_IDLE) && i_rst_n;
    assign bus.o_rsp_valid  = r_rsp_valid;
    assign bus.o_rsp_err    = r_rsp_err;
    assign bus.o_rdata      = (r_rsp_valid && !r_we && !r_rsp_err) ? w_ext : '0;
    assign bus.o_dm_req     = r_dm_req;
    assign bus.o_dm_we      = r_dm_we;
    assign bus.o_dm_be      = r_dm_be;
    assign bus.o_dm_addr    = r_dm_addr;
    assign bus.o_dm_wdata   = r_dm_wdata;
    assign bus.o_mmio_we    = r_mmio_we;
    assign bus.o_mmio_re    = r_mmio_re;
    assign bus.o_mmio_addr  = r_mmio_addr;
    assign bus.o_mmio_wdata = r_mmio_wdata;
endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
- Multi-cycle, parametrised load/store unit between the MEM stage and a synchronous-read, byte-enabled DMEM port plus the MMIO bus.
- Uses a valid/ready request and a one-cycle response pulse so the pipeline can stall.
- Splits any DMEM access that crosses a word boundary into two beats (loads and stores, every size).
- Rejects misaligned MMIO accesses with an error response instead of accessing the bus.

Parameters:
- XLEN, 32, data/bus width in bits, 32 or 64; NB = XLEN/8 byte lanes, OW = log2(NB) offset bits.
- ADDR_W, 32, address width.
- MMIO_BASE, 32'h1000_0000, base of the MMIO region.
- MMIO_MASK, 32'hF000_0000, region mask; is_mmio = ((addr & MMIO_MASK) == MMIO_BASE).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  high only in IDLE.
- i_we  in  1  1 = store, 0 = load.
- i_size  in  2  access size 2^i_size bytes: 0 = B, 1 = H, 2 = W, 3 = D.
- i_unsigned  in  1  zero-extend the load result.
- i_addr  in  ADDR_W  byte address.
- i_wdata  in  XLEN  store data, right-justified.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_err  out  1  qualifies o_rsp_valid: access rejected.
- o_rdata  out  XLEN  extended load data; 0 unless o_rsp_valid and load and not err.
- o_dm_req  out  1  DMEM beat strobe.
- o_dm_we  out  1  DMEM write.
- o_dm_be  out  NB  DMEM byte enables.
- o_dm_addr  out  ADDR_W  DMEM address, NB-aligned.
- o_dm_wdata  out  XLEN  DMEM lane-positioned write data.
- i_dm_rdata  in  XLEN  DMEM read data, valid the cycle after a read beat.
- o_mmio_we  out  1  MMIO write strobe.
- o_mmio_re  out  1  MMIO read strobe.
- o_mmio_addr  out  ADDR_W  MMIO address, unaligned pass-through.
- o_mmio_wdata  out  XLEN  MMIO data, pass-through.
- i_mmio_rdata  in  XLEN  MMIO read data, combinational in the same cycle.

Behaviour:
- Reset (async, any state): state = IDLE, all request registers = 0, every output = 0 except o_req_ready = 1 after release. No strobes may fire in the reset cycle or the cycle after release.
- Accept: on a clock edge with i_req_valid & o_req_ready, latch we/size/unsigned/addr/wdata, off = addr[OW-1:0], addr_al = addr with low OW bits cleared.
  - split = !mmio & (off + 2^size > NB).
  - err = (2^size > NB) | (mmio & (off mod 2^size != 0)).
- FSM IDLE -> ISSUE_LO -> [ISSUE_HI if split] -> RESP -> IDLE. If err: IDLE -> RESP directly, with no bus activity.
- ISSUE_LO, DMEM: o_dm_req = 1, o_dm_addr = addr_al, o_dm_be = (bytemask(size) << off) truncated to NB, o_dm_wdata = wdata << 8*off.
- ISSUE_LO, MMIO: o_mmio_we = we, o_mmio_re = !we, addr/wdata passed through; i_mmio_rdata is captured at the end of the cycle.
- ISSUE_HI: o_dm_addr = addr_al + NB (wraps modulo 2^ADDR_W), o_dm_be = bytemask(size) >> (NB - off), o_dm_wdata = wdata >> 8*(NB - off). The low-beat read data present on i_dm_rdata in this cycle is captured.
- RESP: o_rsp_valid = 1 for exactly one cycle.
  - Load data is extracted starting at byte off of {hi, lo}, using i_dm_rdata as the last beat's word, then sign- or zero-extended from 8 * 2^size bits. Size 3 with XLEN = 32 is never extended because it is always err.
  - MMIO load: the same extraction applied to the captured MMIO word.
  - Stores: o_rdata = 0.
- Latency, accept edge to o_rsp_valid:
  - 2 cycles: aligned or within-word DMEM access, and MMIO.
  - 3 cycles: split access.
  - 1 cycle: err.
- No read-modify-write: stores use byte enables only. Byte lanes outside o_dm_be must not change.
- Back-to-back: o_req_ready rises in the cycle after RESP. Requests offered while busy are ignored, not queued.
- All bus outputs are 0 outside their issuing state. At most one beat is issued per cycle.

Test Plan:
1. XLEN = 32. SW 0x11223344 @0x0, SW 0xAABBCCDD @0x4, then LW @0x1 -> two beats (be 4'b1110, then 4'b0001), o_rdata = 0xDD112233 three cycles after accept.
2. SH 0xBEEF @0x3 -> beat0 addr 0x0, be 4'b1000, wdata 0xEF000000; beat1 addr 0x4, be 4'b0001, wdata 0x000000BE. Then LH @0x3 -> 0xFFFFBEEF; LHU @0x3 -> 0x0000BEEF.
3. LB @0x2 with mem word 0x00800000 -> 0xFFFFFF80, 2-cycle latency, single beat with be 4'b0100. LH @0x1 (within word) -> single beat, no ISSUE_HI.
4. MMIO: LW @0x1000_0002 -> o_rsp_err = 1 one cycle after accept, no o_mmio_re. SW 0x5 @0x1000_0000 -> o_mmio_we pulse for 1 cycle, wdata 0x5.
5. Assert i_rst_n = 0 during ISSUE_HI of a split store -> outputs 0 immediately, no response pulse. After release o_req_ready = 1 and a new LW @0x8 completes normally.
6. XLEN = 64: SD @0x5 splits into be 8'hE0 / 8'h1F and reads back identically. LD @0xFFFF_FFFC wraps the high beat to addr 0x0.
